// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : shared op codes, FSM states and constants for the HI/LO unit
// Rev 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

   localparam int MD_DATA_W = 32;
   localparam logic [MD_DATA_W-1:0] MIN_INT = {1'b1, {(MD_DATA_W-1){1'b0}}};

   typedef enum logic [2:0] {
      MD_DIVU  = 3'd0,
      MD_DIV   = 3'd1,
      MD_MULTU = 3'd2,
      MD_MUL   = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } md_state_e;

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == MD_DIVU) || (op == MD_DIV);
   endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter_core.sv
// ============================================================================
// muldiv_iter_core : one radix-2 step, restoring divide or shift-add multiply
// Rev 1.0
// ============================================================================
`default_nettype none

module muldiv_iter_core #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] acc_i,
   input  logic [DATA_W-1:0] shf_i,
   input  logic [DATA_W-1:0] opnd_i,
   input  logic              div_mode_i,
   output logic [DATA_W-1:0] acc_o,
   output logic [DATA_W-1:0] shf_o
);

   logic [DATA_W:0]   rem_shift;
   logic              rem_ge;
   logic [DATA_W-1:0] rem_diff;
   logic [DATA_W:0]   sum;

   always_comb begin
      rem_shift = {acc_i, shf_i[DATA_W-1]};
      rem_ge    = rem_shift >= {1'b0, opnd_i};
      // true difference is below the divisor, so the low word is exact
      rem_diff  = rem_shift[DATA_W-1:0] - opnd_i;
      sum       = shf_i[0] ? ({1'b0, acc_i} + {1'b0, opnd_i}) : {1'b0, acc_i};

      if (div_mode_i) begin
         acc_o = rem_ge ? rem_diff : rem_shift[DATA_W-1:0];
         shf_o = {shf_i[DATA_W-2:0], rem_ge};
      end else begin
         acc_o = sum[DATA_W:1];
         shf_o = {sum[0], shf_i[DATA_W-1:1]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
// ============================================================================
// muldiv_ctrl : HI/LO sequencer for DIV/DIVU/MULTU/MUL/MTHI/MTLO
// Optional macro MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
// Rev 1.0
// ============================================================================
`default_nettype none

module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int DATA_W = MD_DATA_W,
   parameter int CNT_W  = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              cancel,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic [DATA_W-1:0] mul_result
);

   md_state_e         state_q, state_d;
   md_op_e            op_q, op_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] shf_q, shf_d;
   logic [DATA_W-1:0] opnd_q, opnd_d;
   logic              a_neg_q, a_neg_d;
   logic              q_neg_q, q_neg_d;
   logic              b_zero_q, b_zero_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic [DATA_W-1:0] mres_q, mres_d;
   logic              done_q, done_d;

   logic [DATA_W-1:0] step_acc, step_shf;
   logic [DATA_W-1:0] quo_fix, rem_fix;
   logic              div_signed, b_neg;

`ifdef MULDIV_FAST_MUL_EN
   logic [2*DATA_W-1:0] prod;
   assign prod = a * b;
`endif

   muldiv_iter_core #(
      .DATA_W     (DATA_W)
   ) u_core (
      .acc_i      (acc_q),
      .shf_i      (shf_q),
      .opnd_i     (opnd_q),
      .div_mode_i (is_div_op(op_q)),
      .acc_o      (step_acc),
      .shf_o      (step_shf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= MD_DIVU;
         cnt_q    <= '0;
         acc_q    <= '0;
         shf_q    <= '0;
         opnd_q   <= '0;
         a_neg_q  <= 1'b0;
         q_neg_q  <= 1'b0;
         b_zero_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         mres_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         shf_q    <= shf_d;
         opnd_q   <= opnd_d;
         a_neg_q  <= a_neg_d;
         q_neg_q  <= q_neg_d;
         b_zero_q <= b_zero_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         mres_q   <= mres_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      shf_d      = shf_q;
      opnd_d     = opnd_q;
      a_neg_d    = a_neg_q;
      q_neg_d    = q_neg_q;
      b_zero_d   = b_zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      mres_d     = mres_q;
      done_d     = 1'b0;
      div_signed = (op == MD_DIV);
      b_neg      = div_signed & b[DATA_W-1];
      quo_fix    = q_neg_q ? -shf_q : shf_q;
      rem_fix    = a_neg_q ? -acc_q : acc_q;

      case (state_q)
         ST_IDLE: begin
            if (start && !cancel) begin
               case (op)
                  MD_DIVU, MD_DIV: begin
                     // the core divides magnitudes; signs are restored in FIX
                     op_d     = md_op_e'(op);
                     a_neg_d  = div_signed & a[DATA_W-1];
                     q_neg_d  = (div_signed & a[DATA_W-1]) ^ b_neg;
                     b_zero_d = (b == '0);
                     acc_d    = '0;
                     shf_d    = (div_signed & a[DATA_W-1]) ? -a : a;
                     opnd_d   = b_neg ? -b : b;
                     cnt_d    = '0;
                     state_d  = ST_RUN;
                  end
                  MD_MULTU, MD_MUL: begin
                     // MUL's low word equals the unsigned product's low word
                     op_d     = md_op_e'(op);
                     a_neg_d  = 1'b0;
                     q_neg_d  = 1'b0;
                     b_zero_d = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
                     acc_d    = prod[2*DATA_W-1:DATA_W];
                     shf_d    = prod[DATA_W-1:0];
                     opnd_d   = a;
                     state_d  = ST_FIX;
`else
                     acc_d    = '0;
                     shf_d    = b;
                     opnd_d   = a;
                     cnt_d    = '0;
                     state_d  = ST_RUN;
`endif
                  end
                  MD_MTHI: begin
                     hi_d   = a;
                     done_d = 1'b1;
                  end
                  MD_MTLO: begin
                     lo_d   = a;
                     done_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end

         ST_RUN: begin
            if (cancel) begin
               state_d = ST_IDLE;
            end else begin
               acc_d = step_acc;
               shf_d = step_shf;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DATA_W-1)) begin
                  state_d = ST_FIX;
               end
            end
         end

         ST_FIX: begin
            state_d = ST_IDLE;
            if (!cancel) begin
               done_d = 1'b1;
               case (op_q)
                  MD_DIVU, MD_DIV: begin
                     hi_d = rem_fix;
                     lo_d = b_zero_q ? '1 : quo_fix;
                  end
                  MD_MULTU: begin
                     hi_d = acc_q;
                     lo_d = shf_q;
                  end
                  MD_MUL: begin
                     mres_d = shf_q;
                  end
                  default: done_d = 1'b0;
               endcase
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign busy       = (state_q != ST_IDLE);
   assign done       = done_q;
   assign hi         = hi_q;
   assign lo         = lo_q;
   assign mul_result = mres_q;

endmodule

`default_nettype wire
